// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: arbiter-PUF challenge sequencer with repeated evaluation and majority vote.
// Optional macro PUF_XOR_OUT_EN builds the XOR-reduced response output oxor.
module puf_eval_ctrl #(
   parameter int C_LENGTH      = 32,
   parameter int N_CHAINS      = 4,
   parameter int N_REPEAT      = 7,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                iclk,
   input  logic                irst_n,
   input  logic                istart,
   input  logic                iabort,
   input  logic [C_LENGTH-1:0] ichallenge,
   input  logic [N_CHAINS-1:0] iarb,
   output logic                ordy,
   output logic                opulse,
   output logic [C_LENGTH-1:0] ochallenge,
   output logic                ovalid,
   output logic [N_CHAINS-1:0] oresponse,
   output logic [N_CHAINS-1:0] ostable,
   output logic                oxor
);
   localparam int CW = $clog2(N_REPEAT + 1);
   localparam int PW = $clog2(SETTLE_CYCLES);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RISE   = 3'd1;
   localparam logic [2:0] SAMPLE = 3'd2;
   localparam logic [2:0] FALL   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]                   state_q, state_d;
   logic [PW-1:0]                phase_q, phase_d;
   logic [CW-1:0]                rep_q, rep_d;
   logic [N_CHAINS-1:0][CW-1:0]  ones_q, ones_d;
   logic [N_CHAINS-1:0]          sync1_q, sync2_q;
   logic [C_LENGTH-1:0]          chal_q;
   logic [N_CHAINS-1:0]          resp_q, resp_d, stab_q, stab_d;
   logic                         rdy_q, pulse_q, valid_q;
   logic                         accept, phase_end, upd;

   always_comb begin
      accept    = istart && state_q == IDLE;
      phase_end = phase_q == PW'(SETTLE_CYCLES - 1);
      state_d   = state_q;
      phase_d   = phase_q;
      rep_d     = rep_q;
      ones_d    = ones_q;
      upd       = 1'b0;
      for (int c = 0; c < N_CHAINS; c++) begin
         resp_d[c] = ones_q[c] > CW'(N_REPEAT / 2);
         stab_d[c] = ones_q[c] == '0 || ones_q[c] == CW'(N_REPEAT);
      end
      if (iabort && state_q != IDLE)
         state_d = IDLE;
      else
         case (state_q)
            IDLE: if (accept) begin
               state_d = RISE;
               phase_d = '0;
               rep_d   = '0;
               ones_d  = '0;
            end
            RISE: begin
               phase_d = phase_end ? '0 : phase_q + 1'b1;
               state_d = phase_end ? SAMPLE : RISE;
            end
            SAMPLE: begin
               for (int c = 0; c < N_CHAINS; c++)
                  ones_d[c] = ones_q[c] + CW'(sync2_q[c]);
               state_d = FALL;
            end
            FALL: begin
               phase_d = phase_end ? '0 : phase_q + 1'b1;
               if (phase_end) begin
                  upd     = rep_q == CW'(N_REPEAT - 1);
                  state_d = upd ? DONE : RISE;
                  rep_d   = upd ? rep_q : rep_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
   end

   // Outputs are registered from the next state so they line up with the FSM cycle.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         rep_q   <= '0;
         ones_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         chal_q  <= '0;
         resp_q  <= '0;
         stab_q  <= '0;
         rdy_q   <= 1'b1;
         pulse_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rep_q   <= rep_d;
         ones_q  <= ones_d;
         sync1_q <= iarb;
         sync2_q <= sync1_q;
         if (accept) chal_q <= ichallenge;
         if (upd) begin
            resp_q <= resp_d;
            stab_q <= stab_d;
         end
         rdy_q   <= state_d == IDLE;
         pulse_q <= state_d == RISE || state_d == SAMPLE;
         valid_q <= state_d == DONE;
      end
   end

`ifdef PUF_XOR_OUT_EN
   logic xor_q;
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) xor_q <= 1'b0;
      else if (upd) xor_q <= ^resp_d;
   end
   assign oxor = xor_q;
`else
   assign oxor = 1'b0;
`endif

   assign ordy       = rdy_q;
   assign opulse     = pulse_q;
   assign ochallenge = chal_q;
   assign ovalid     = valid_q;
   assign oresponse  = resp_q;
   assign ostable    = stab_q;
endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencing controller for a bank of arbiter-PUF delay lines. It accepts a challenge through a ready/start handshake and drives it, together with the launch pulse, to `N_CHAINS` parallel mux delay chains. Each evaluation is repeated `N_REPEAT` times, with the arbiter outputs synchronised and counted, and a majority-voted response plus a stability flag is returned per chain. The block sits between the system bus/test logic and the delay-line/arbiter macros.

## Interface
Parameters:
- `C_LENGTH`, 32, challenge bits per chain (mux stages).
- `N_CHAINS`, 4, number of parallel delay chains/arbiters.
- `N_REPEAT`, 7, evaluations per challenge; must be odd, ≥1.
- `SETTLE_CYCLES`, 8, cycles per pulse phase; must be ≥3.

Ports:
- `iclk`  in  1  clock.
- `irst_n`  in  1  asynchronous, active-low reset.
- `istart`  in  1  request evaluation; accepted when `istart && ordy`.
- `iabort`  in  1  cancel evaluation in progress.
- `ichallenge`  in  C_LENGTH  challenge, sampled on acceptance.
- `iarb`  in  N_CHAINS  raw arbiter outputs (asynchronous to `iclk`).
- `ordy`  out  1  idle, ready to accept.
- `opulse`  out  1  launch pulse to all chains.
- `ochallenge`  out  C_LENGTH  held challenge to all chains.
- `ovalid`  out  1  one-cycle strobe: response updated.
- `oresponse`  out  N_CHAINS  majority-voted response.
- `ostable`  out  N_CHAINS  1 = all `N_REPEAT` samples agreed.
- `oxor`  out  1  XOR-PUF bit (see Configuration).

## Operation
- `iarb` passes through a 2-flop synchroniser per bit; only synchronised values are counted.
- Per-chain ones counters are `$clog2(N_REPEAT+1)` bits wide and saturate-free, since the count is ≤ `N_REPEAT` by construction. The repeat counter uses the same width. The phase counter is `$clog2(SETTLE_CYCLES)` bits wide.
- FSM states:
  - IDLE: `ordy`=1, `opulse`=0. On accept, `ochallenge` ← `ichallenge`, counters cleared, go to RISE.
  - RISE: `opulse`=1 for `SETTLE_CYCLES` cycles, then go to SAMPLE.
  - SAMPLE: `opulse`=1 for 1 cycle. Each ones counter increments by its synchronised `iarb` bit. Go to FALL.
  - FALL: `opulse`=0 for `SETTLE_CYCLES` cycles. The arbiter relaxes. If repeats are done, go to DONE; else go to RISE.
  - DONE: 1 cycle. `oresponse[c]` ← (ones[c] > `N_REPEAT`/2). `ostable[c]` ← (ones[c]==0 or ones[c]==`N_REPEAT`). `ovalid`=1. Go to IDLE.
- `oresponse`, `ostable`, `oxor` hold their values until the next DONE.
- `ochallenge` holds from acceptance until the next acceptance.
- `istart` while `ordy`=0 is ignored. No queuing.
- `iabort` in any non-IDLE state: go to IDLE next cycle, `opulse`=0, no `ovalid`, result registers unchanged. `iabort` has priority over FSM progression. `iabort` in IDLE has no effect, and `istart`+`iabort` both high in IDLE means the start is accepted.
- Reset mid-evaluation: all state is cleared immediately and asynchronously. `opulse` drops without waiting for a phase boundary.

## Timing
- Reset values:
  - `ordy`=1.
  - `opulse`=0, `ovalid`=0.
  - `ochallenge`=0, `oresponse`=0, `ostable`=0, `oxor`=0.
  - Synchronisers, FSM state, and all counters cleared.
- Accept edge = cycle 0. RISE occupies cycles 1..S, SAMPLE is cycle S+1, FALL occupies S+2..2S+1.
- One evaluation takes 2·S+1 cycles.
- `ovalid` is high in cycle `N_REPEAT`·(2·S+1)+1. `ordy` returns in the following cycle.
  - Defaults: `ovalid` at cycle 120, `ordy` at cycle 121.
- Sampled `iarb` reflects the arbiter state at least S−2 cycles after the pulse edge, which is why `SETTLE_CYCLES` ≥3.
- All outputs are registered.

## Configuration
- `PUF_XOR_OUT_EN` defined: at DONE, `oxor` ← XOR-reduce of the new `oresponse` (N_CHAINS-input XOR arbiter PUF).
- `PUF_XOR_OUT_EN` undefined: `oxor` is tied to 0 and no reduction logic is built.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset then idle: `ordy`=1 and all other outputs 0. `istart` pulse with `ichallenge`=32'hA5A5_0F0F → `ochallenge`=32'hA5A5_0F0F from cycle 1, and `opulse` high during cycles 1..9, 18..26, etc.
- `iarb`=4'b1010 held constant → `ovalid` at cycle 120, `oresponse`=4'b1010, `ostable`=4'b1111, `oxor`=0 (with `PUF_XOR_OUT_EN`).
- `iarb[0]` high on 4 of 7 samples, `iarb[1]` high on 3 of 7 → `oresponse[1:0]`=2'b01, `ostable[1:0]`=2'b00.
- `iabort` at cycle 40 → `opulse`=0 and `ordy`=1 from cycle 41, no `ovalid`, previous `oresponse` retained.
- `istart` held high through a whole evaluation → exactly one `ovalid` per accepted start, with the next accept in the cycle `ordy` rises (cycle 121).
- `irst_n` asserted at cycle 50 during RISE → `opulse` and all outputs drop asynchronously to their reset values, and the bench confirms no glitch on `ovalid`.
